// File: rtl/data_mem_bridge_pkg.sv
// Shared encodings for the data memory bridge: access sizes, FSM states,
// full byte-enable mask and the alignment rule.
package data_mem_bridge_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

  // Size code 2'b11 is handled as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmb_lane_fmt.sv
// Little-endian lane formatter: byte enables and replicated store data on the
// way out, lane selection and sign/zero extension of load data on the way in.
module dmb_lane_fmt
  import data_mem_bridge_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [1:0]  lane;
  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // Halves and words ignore the address bits below their natural alignment.
  always_comb begin
    lane      = 2'b00;
    be        = BE_ALL;
    wdata_rep = wdata;
    case (size)
      SZ_BYTE: begin
        lane      = addr_lo;
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        lane      = {addr_lo[1], 1'b0};
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: begin
        lane      = 2'b00;
        be        = BE_ALL;
        wdata_rep = wdata;
      end
    endcase
  end

  always_comb begin
    sel_b = rdata[7:0];
    case (lane)
      2'd0:    sel_b = rdata[7:0];
      2'd1:    sel_b = rdata[15:8];
      2'd2:    sel_b = rdata[23:16];
      default: sel_b = rdata[31:24];
    endcase
    sel_h = lane[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    rdata_ext = rdata;
    case (size)
      SZ_BYTE: rdata_ext = {{24{sign & sel_b[7]}}, sel_b};
      SZ_HALF: rdata_ext = {{16{sign & sel_h[15]}}, sel_h};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/data_mem_bridge.sv
// M-stage to multi-cycle data bus bridge with pipeline stall and watchdog.
// Define DMB_MISALIGN_EXC_EN to reject misaligned half/word accesses.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en_i,
  input  logic        mem_wr_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        bus_req_o,
  output logic        bus_wr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_addr_ok_i,
  input  logic        bus_data_ok_i,
  input  logic [31:0] bus_rdata_i
);

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  state_e          state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]      lo_q;
  logic [1:0]      size_q;
  logic            sign_q;

  logic            misaligned;
  logic            issue;
  logic            done_ok;
  logic            timeout;
  logic [1:0]      fmt_lo;
  logic [1:0]      fmt_size;
  logic [3:0]      fmt_be;
  logic [31:0]     fmt_wdata;
  logic [31:0]     fmt_rdata;

`ifdef DMB_MISALIGN_EXC_EN
  assign misaligned = is_misaligned(size_i, addr_i[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign issue      = (state == ST_IDLE) && mem_en_i && !misaligned;
  assign stall_o    = !rst && (issue || state == ST_REQ || state == ST_WAIT);
  assign misalign_o = !rst && (state == ST_IDLE) && mem_en_i && misaligned;

  assign done_ok = ((state == ST_REQ) && bus_addr_ok_i && bus_data_ok_i) ||
                   ((state == ST_WAIT) && bus_data_ok_i);
  assign timeout = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

  // One formatter serves both directions: in IDLE it formats the incoming
  // store, afterwards it extracts the load from the latched lane/size.
  assign fmt_lo   = (state == ST_IDLE) ? addr_i[1:0] : lo_q;
  assign fmt_size = (state == ST_IDLE) ? size_i : size_q;

  dmb_lane_fmt u_fmt (
    .addr_lo  (fmt_lo),
    .size     (fmt_size),
    .sign     (sign_q),
    .wdata    (wdata_i),
    .rdata    (bus_rdata_i),
    .be       (fmt_be),
    .wdata_rep(fmt_wdata),
    .rdata_ext(fmt_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      lo_q        <= '0;
      size_q      <= '0;
      sign_q      <= 1'b0;
      rdata_o     <= '0;
      bus_err_o   <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_wr_o    <= 1'b0;
      bus_be_o    <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
    end else begin
      bus_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (issue) begin
            lo_q        <= addr_i[1:0];
            size_q      <= size_i;
            sign_q      <= sign_i;
            bus_wr_o    <= mem_wr_i;
            bus_be_o    <= fmt_be;
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_wdata_o <= fmt_wdata;
            bus_req_o   <= 1'b1;
            cnt         <= '0;
            state       <= ST_REQ;
          end
        end
        ST_REQ, ST_WAIT: begin
          // A completing handshake wins over the watchdog in the same cycle.
          if (done_ok) begin
            state     <= ST_DONE;
            bus_req_o <= 1'b0;
            if (!bus_wr_o) rdata_o <= fmt_rdata;
          end else if (timeout) begin
            state     <= ST_DONE;
            bus_req_o <= 1'b0;
            bus_err_o <= 1'b1;
            if (!bus_wr_o) rdata_o <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (state == ST_REQ && bus_addr_ok_i) begin
              state     <= ST_WAIT;
              bus_req_o <= 1'b0;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Randomized scoreboard bench for data_mem_bridge with a byte-level memory
// reference model and a latency-programmable bus responder.
module tb_data_mem_bridge;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_en_i, mem_wr_i, sign_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o, misalign_o, bus_err_o;
  logic        bus_req_o, bus_wr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic        bus_addr_ok_i, bus_data_ok_i;
  logic [31:0] bus_rdata_i;

  data_mem_bridge #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .mem_en_i(mem_en_i), .mem_wr_i(mem_wr_i), .size_i(size_i), .sign_i(sign_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .bus_req_o(bus_req_o),
    .bus_wr_o(bus_wr_o), .bus_be_o(bus_be_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_addr_ok_i(bus_addr_ok_i),
    .bus_data_ok_i(bus_data_ok_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct { logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_exp_t;
  typedef struct { int stall; logic [31:0] rdata; logic err; } done_exp_t;
  typedef struct { int a; int d; bit never; bit spur; } dly_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  dly_t      dly_q[$];

  logic [7:0]  rmem[64];
  logic [31:0] bmem[16];
  logic [31:0] last_rd = '0;
  bit          quiet = 1'b0;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input bit sgn);
    int unsigned n = nbytes(size);
    logic [31:0] eff = addr & ~(n - 1);
    logic [31:0] v = '0;
    for (int unsigned i = 0; i < n; i++) v = v | (32'(rmem[(eff + i) % 64]) << (8 * i));
    if (sgn && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    bmem[addr[5:2]] = val;
    for (int unsigned i = 0; i < 4; i++) rmem[{addr[5:2], 2'b00} + i] = val[8 * i +: 8];
  endtask

  // One core access, held until the bridge releases the stall.
  task automatic access(input bit wr, input logic [1:0] size, input bit sgn,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int a, input int d, input bit never, input bit spur);
    int unsigned n = nbytes(size);
    logic [31:0] eff = addr & ~(n - 1);
    bit mis = (size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
    bit abort = never || (a + d > int'(TO) - 1);
    bus_exp_t be_e;
    done_exp_t de;
    bit fin = 1'b0;
    @(negedge clk);
    mem_en_i = 1'b1; mem_wr_i = wr; size_i = size; sign_i = sgn; addr_i = addr; wdata_i = wd;
`ifdef DMB_MISALIGN_EXC_EN
    if (mis) begin
      #1;
      check("misalign_pulse", 32'(misalign_o), 32'd1);
      check("misalign_stall", 32'(stall_o), 32'd0);
      @(negedge clk);
      mem_en_i = 1'b0;
      check("misalign_no_req", 32'(bus_req_o), 32'd0);
      return;
    end
`else
    if (mis) check("forced_align_misalign", 32'(misalign_o), 32'd0);
`endif
    be_e.wr = wr; be_e.addr = addr & 32'hFFFF_FFFC; be_e.be = '0; be_e.wdata = '0;
    for (int unsigned i = 0; i < n; i++) be_e.be[((eff & 3) + i) % 4] = 1'b1;
    for (int unsigned k = 0; k < 4; k++) be_e.wdata[8 * k +: 8] = wd[8 * (k % n) +: 8];
    bus_q.push_back(be_e);
    dly_q.push_back('{a: a, d: d, never: never, spur: spur});
    if (wr) begin
      if (!abort) for (int unsigned i = 0; i < n; i++) rmem[(eff + i) % 64] = wd[8 * i +: 8];
    end else begin
      last_rd = abort ? 32'h0 : ref_load(addr, size, sgn);
    end
    de.stall = abort ? 1 + int'(TO) : 2 + a + d;
    de.rdata = last_rd;
    de.err   = abort;
    done_q.push_back(de);
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge clk);
      if (stall_o === 1'b0) fin = 1'b1;
      else begin
        // The core holds M while stalled; scrambling the inputs must not matter.
        mem_en_i = 1'($urandom_range(0, 1)); mem_wr_i = 1'($urandom_range(0, 1));
        size_i = 2'($urandom_range(0, 3)); sign_i = 1'($urandom_range(0, 1));
        addr_i = $urandom; wdata_i = $urandom;
      end
    end
    if (!fin) check("stall_release_timeout", 32'd0, 32'd1);
    mem_en_i = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  // Bus responder: latency per transaction comes from dly_q.
  initial begin
    dly_t t;
    bit alive, wr;
    logic [3:0] be;
    logic [31:0] ad, wd;
    bus_addr_ok_i = 1'b0; bus_data_ok_i = 1'b0; bus_rdata_i = $urandom;
    forever begin
      @(negedge clk);
      bus_rdata_i = $urandom;
      if (bus_req_o === 1'b1 && dly_q.size() > 0) begin
        t = dly_q.pop_front();
        wr = bus_wr_o; be = bus_be_o; ad = bus_addr_o; wd = bus_wdata_o;
        alive = 1'b1;
        for (int i = 0; i < t.a && alive; i++) begin
          bus_addr_ok_i = 1'b0;
          bus_data_ok_i = t.spur & 1'($urandom_range(0, 1));
          @(negedge clk);
          bus_rdata_i = $urandom;
          if (bus_req_o !== 1'b1) alive = 1'b0;
        end
        if (alive) begin
          bus_addr_ok_i = 1'b1;
          bus_data_ok_i = (t.d == 0) && !t.never;
          if (bus_data_ok_i) begin
            if (wr) begin
              for (int l = 0; l < 4; l++) if (be[l]) bmem[ad[5:2]][8 * l +: 8] = wd[8 * l +: 8];
            end else bus_rdata_i = bmem[ad[5:2]];
          end
          @(negedge clk);
          bus_addr_ok_i = 1'b0; bus_data_ok_i = 1'b0; bus_rdata_i = $urandom;
          if (t.never) begin
            for (int g = 0; g < 50 && stall_o !== 1'b0; g++) begin
              @(negedge clk);
              bus_rdata_i = $urandom;
            end
          end else if (t.d > 0) begin
            repeat (t.d - 1) begin
              @(negedge clk);
              bus_rdata_i = $urandom;
            end
            bus_data_ok_i = 1'b1;
            if (wr) begin
              for (int l = 0; l < 4; l++) if (be[l]) bmem[ad[5:2]][8 * l +: 8] = wd[8 * l +: 8];
            end else bus_rdata_i = bmem[ad[5:2]];
            @(negedge clk);
            bus_data_ok_i = 1'b0; bus_rdata_i = $urandom;
          end
        end
        bus_addr_ok_i = 1'b0; bus_data_ok_i = 1'b0;
      end
    end
  end

  // Monitor: checks bus request contents and each completed transaction.
  initial begin
    int run = 0;
    bit prev_req = 1'b0;
    bus_exp_t e;
    done_exp_t x;
    forever begin
      @(negedge clk);
      #2;
      if (quiet) begin
        run = 0;
        prev_req = bus_req_o;
        continue;
      end
      if (bus_req_o === 1'b1 && !prev_req) begin
        if (bus_q.size() == 0) check("bus_unexpected_req", 32'd1, 32'd0);
        else begin
          e = bus_q.pop_front();
          check("bus_wr", 32'(bus_wr_o), 32'(e.wr));
          check("bus_addr", bus_addr_o, e.addr);
          check("bus_be", 32'(bus_be_o), 32'(e.be));
          if (e.wr) check("bus_wdata", bus_wdata_o, e.wdata);
        end
      end
      prev_req = (bus_req_o === 1'b1);
      if (stall_o === 1'b1) run++;
      else begin
        if (run > 0) begin
          if (done_q.size() == 0) check("unexpected_completion", 32'd1, 32'd0);
          else begin
            x = done_q.pop_front();
            check("stall_len", 32'(run), 32'(x.stall));
            check("rdata", rdata_o, x.rdata);
            check("bus_err", 32'(bus_err_o), 32'(x.err));
            check("req_dropped", 32'(bus_req_o), 32'd0);
            check("misalign_done", 32'(misalign_o), 32'd0);
          end
        end else check("bus_err_idle", 32'(bus_err_o), 32'd0);
        run = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    logic [31:0] v;
    rst = 1'b1;
    mem_en_i = 1'b0; mem_wr_i = 1'b0; size_i = '0; sign_i = 1'b0; addr_i = '0; wdata_i = '0;
    for (int w = 0; w < 16; w++) begin
      v = $urandom;
      preload(32'(w * 4), v);
    end
    repeat (3) @(negedge clk);
    #1;
    check("rst_rdata", rdata_o, 32'h0);
    check("rst_req", 32'(bus_req_o), 32'd0);
    check("rst_wr", 32'(bus_wr_o), 32'd0);
    check("rst_be", 32'(bus_be_o), 32'd0);
    check("rst_addr", bus_addr_o, 32'h0);
    check("rst_wdata", bus_wdata_o, 32'h0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_misalign", 32'(misalign_o), 32'd0);
    check("rst_err", 32'(bus_err_o), 32'd0);
    rst = 1'b0;

    access(1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0);
    preload(32'h100, 32'h80FF_FF01);
    access(0, 2'b00, 1, 32'h103, 32'h0, 0, 3, 0, 0);
    access(0, 2'b00, 0, 32'h103, 32'h0, 0, 3, 0, 0);
    access(1, 2'b01, 0, 32'h102, 32'h5555_1234, 0, 0, 0, 0);
    preload(32'h100, 32'hABCD_0000);
    access(0, 2'b01, 0, 32'h102, 32'h0, 1, 1, 0, 1);
    access(0, 2'b10, 0, 32'h200, 32'h0, 0, 0, 1, 0);
    access(0, 2'b10, 0, 32'h204, 32'h0, 6, 0, 1, 1);
    access(1, 2'b10, 0, 32'h208, 32'h1111_2222, 1, 0, 1, 0);
    access(0, 2'b10, 0, 32'h101, 32'h0, 0, 0, 0, 0);
    access(1, 2'b01, 0, 32'h107, 32'hCAFE_F00D, 2, 1, 0, 0);
    access(0, 2'b11, 1, 32'h10A, 32'h0, 2, 1, 0, 0);

    for (int i = 0; i < 80; i++) begin
      bit nv = ($urandom_range(0, 9) == 0);
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, nv ? $urandom_range(0, 5) : $urandom_range(0, 2),
             $urandom_range(0, 1), nv, ($urandom_range(0, 3) == 0));
    end

    // Reset while the bridge waits for data_ok.
    preload(32'h40, 32'h0000_0055);
    access(0, 2'b10, 0, 32'h40, 32'h0, 0, 0, 0, 0);
    @(negedge clk);
    mem_en_i = 1'b1; mem_wr_i = 1'b0; size_i = 2'b10; sign_i = 1'b0; addr_i = 32'h44; wdata_i = '0;
    bus_q.push_back('{wr: 1'b0, addr: 32'h44, be: 4'hF, wdata: 32'h0});
    dly_q.push_back('{a: 0, d: 0, never: 1'b1, spur: 1'b0});
    @(negedge clk);
    @(negedge clk);
    quiet = 1'b1;
    rst = 1'b1;
    mem_en_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_req", 32'(bus_req_o), 32'd0);
    check("midrst_stall", 32'(stall_o), 32'd0);
    check("midrst_rdata", rdata_o, 32'h0);
    check("midrst_err", 32'(bus_err_o), 32'd0);
    #3;
    quiet = 1'b0;
    last_rd = 32'h0;
    access(0, 2'b10, 0, 32'h40, 32'h0, 0, 1, 0, 0);

    repeat (4) @(negedge clk);
    if (done_q.size() != 0) check("pending_completions", 32'(done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
- Sits directly downstream of the pipelined MIPS core's memory stage, between the core's data port and a multi-cycle data RAM bus.
- Turns each single-cycle M-stage load/store into a req / addr_ok / data_ok bus transaction.
- Stalls the pipeline until the transaction completes.
- Generates byte enables and replicated store data; extracts and sign/zero-extends load data.

Parameters:
- TIMEOUT_CYC, 255: cycles allowed in REQ+WAIT before abort; 0 disables the watchdog.
- CNT_W, 8: width of the watchdog counter; must satisfy TIMEOUT_CYC < 2^CNT_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- mem_en_i  in  1  M-stage load/store valid
- mem_wr_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 half, 10 word (11 treated as word)
- sign_i  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr_i  in  32  byte address (core aluoutM)
- wdata_i  in  32  store data (core writedataM), value in low bits
- rdata_o  out  32  aligned, extended load result (core readdataM)
- stall_o  out  1  freeze pipeline while high
- misalign_o  out  1  address-error pulse (see Optional Feature)
- bus_err_o  out  1  one-cycle pulse on watchdog abort
- bus_req_o  out  1  bus request
- bus_wr_o  out  1  bus write
- bus_be_o  out  4  byte enables, bit i = byte lane i
- bus_addr_o  out  32  word-aligned address (low two bits 00)
- bus_wdata_o  out  32  lane-replicated write data
- bus_addr_ok_i  in  1  request accepted
- bus_data_ok_i  in  1  read data valid / write done
- bus_rdata_i  in  32  read data word

Behaviour:
- Endianness: little-endian lanes.
- Byte access: be = 1 << addr[1:0]; wdata = {4{wdata_i[7:0]}}.
- Half access: be = addr[1] ? 1100 : 0011; wdata = {2{wdata_i[15:0]}}.
- Word access: be = 1111; wdata = wdata_i.
- Loads: lane selected by the latched addr[1:0]; result extended to 32 bits per the latched sign flag. On a load, bus_be_o carries the access enables.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: when mem_en_i is high and the access is aligned:
  - latch addr, size, sign, wr and the formatted wdata/be;
  - go to REQ;
  - stall_o is combinationally high in this cycle.
- REQ: bus_req_o = 1, all bus_* outputs driven from the latched values.
  - addr_ok & data_ok in the same cycle -> DONE.
  - addr_ok only -> WAIT.
  - Otherwise stay in REQ.
- WAIT: bus_req_o = 0; data_ok -> DONE. A data_ok arriving while in REQ without addr_ok is ignored.
- DONE: stall_o = 0, which lets the core advance on this edge.
  - Loads: rdata_o is registered on the REQ/WAIT -> DONE edge and holds its value until the next load completes.
  - Next state is always IDLE. A new access is seen at the earliest in the following cycle.
- stall_o = (IDLE & mem_en_i & issuing) | REQ | WAIT.
- Minimum latency: 2 stall cycles (IDLE, REQ with both oks). Each cycle of bus delay adds one.
- Watchdog: the counter clears on entry to REQ and increments in REQ/WAIT.
  - When count == TIMEOUT_CYC - 1 without completion: go to DONE, pulse bus_err_o, load result = 0, bus_req_o dropped.
- Reset values: state IDLE; rdata_o 0; all bus_* outputs 0; stall_o 0; misalign_o 0; bus_err_o 0; counter 0.
- Reset mid-transaction: the FSM returns to IDLE and bus_req_o drops the next cycle. The bus is reset by the same rst, so no stale data_ok can arrive.
- mem_en_i is sampled only in IDLE. Changes while stalled are ignored, since the core holds its M stage.

Optional Feature:
- Macro: DMB_MISALIGN_EXC_EN.
- Defined:
  - A half access with addr[0] = 1, or a word access with addr[1:0] != 00, is not issued.
  - misalign_o pulses for one cycle combinationally in IDLE, with stall_o = 0.
  - rdata_o and the bus are unchanged.
- Undefined:
  - misalign_o is tied 0.
  - For halves, addr[0] is forced to 0; for words, addr[1:0] are forced to 00 before lane selection, so the access proceeds.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state encoding;
  - a 4'b1111 BE_ALL constant.
- One natural sub-module: dmb_lane_fmt, combinational. It takes addr[1:0], size, sign, wdata and rdata, and produces be, replicated wdata and the extended load data.
- The FSM and watchdog stay in the top module.

Test Plan:
- Test 1: sw 0xDEADBEEF @0x100, bus acks addr_ok & data_ok in the same cycle as req.
  - be 1111, bus_addr 0x100.
  - stall high for exactly 2 cycles, low in DONE.
- Test 2: lb signed @0x103, bus returns 0x80FF_FF01 after 3 WAIT cycles.
  - rdata_o = 0xFFFFFF80.
  - With lbu: rdata_o = 0x00000080.
  - stall length = 2 + 3.
- Test 3: sh 0x1234 @0x102.
  - be 1100, bus_wdata 0x12341234.
  - lhu @0x102 with rdata 0xABCD0000 -> rdata_o 0x0000ABCD.
- Test 4: TIMEOUT_CYC = 4, bus never gives data_ok.
  - bus_err_o pulses once, rdata_o = 0.
  - stall drops after 4 REQ/WAIT cycles, FSM back in IDLE.
- Test 5: with DMB_MISALIGN_EXC_EN, lw @0x101.
  - misalign_o pulses 1 cycle, no bus_req, stall 0.
  - Without the macro: bus_addr 0x100, be 1111.
- Test 6: assert rst while in WAIT.
  - Next cycle: state IDLE, bus_req_o 0, stall_o 0, rdata_o 0.
